// File: rtl/ppu_pkg.sv
// Shared widths, int8 limits and the requantisation configuration record
// used by the opsum post-processing unit.
package ppu_pkg;
    localparam int PSUM_W = 32;
    localparam int MULT_W = 16;
    localparam int PACK   = 4;
    localparam int OUT_W  = 8 * PACK;
    localparam int PROD_W = PSUM_W + MULT_W;
    localparam int CNT_W  = $clog2(PACK);

    localparam logic signed [7:0] INT8_MIN = 8'sh80;
    localparam logic signed [7:0] INT8_MAX = 8'sh7F;

    localparam logic [CNT_W-1:0] K_LAST = CNT_W'(PACK - 1);
    localparam logic [CNT_W-1:0] K_ONE  = CNT_W'(1);

    typedef struct packed {
        logic [MULT_W-1:0] mult;
        logic [4:0]        shift;
        logic signed [7:0] zp;
        logic              relu;
    } ppu_cfg_t;

    localparam ppu_cfg_t CFG_RESET = '{mult: 16'd1, shift: 5'd0, zp: 8'sd0, relu: 1'b0};

    function automatic logic [7:0] sat_int8(input logic signed [PROD_W+1:0] v);
        logic signed [PROD_W+1:0] hi;
        logic signed [PROD_W+1:0] lo;
        hi = {{(PROD_W-6){INT8_MAX[7]}}, INT8_MAX};
        lo = {{(PROD_W-6){INT8_MIN[7]}}, INT8_MIN};
        if (v > hi) begin
            return INT8_MAX;
        end else if (v < lo) begin
            return INT8_MIN;
        end else begin
            return v[7:0];
        end
    endfunction
endpackage

// File: rtl/ppu_requant.sv
// Two-stage requantiser: S1 forms the 48-bit signed product, S2 applies the
// rounding shift, optional ReLU, zero-point add and int8 saturation.
module ppu_requant
    import ppu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  ppu_cfg_t          cfg,
    input  logic              in_valid,
    input  logic [PSUM_W-1:0] in_data,
    input  logic              in_last,
    output logic              stage_valid,
    output logic              out_valid,
    output logic [7:0]        out_data,
    output logic              out_last
);
    localparam logic [PROD_W:0] RND_ONE = {{PROD_W{1'b0}}, 1'b1};

    logic signed [PROD_W-1:0] prod_d, prod_q;
    logic                     s1_valid_d, s1_valid_q;
    logic                     s1_last_d, s1_last_q;
    logic signed [PROD_W:0]   rnd, biased, shifted, relu_v;
    logic signed [PROD_W+1:0] zp_sum;
    logic [7:0]               res_d, res_q;
    logic                     s2_valid_d, s2_valid_q;
    logic                     s2_last_d, s2_last_q;

    // S1: signed psum times zero-extended multiplier, both widened to the product width
    always_comb begin
        prod_d     = prod_q;
        s1_valid_d = s1_valid_q;
        s1_last_d  = s1_last_q;
        if (en) begin
            prod_d     = $signed({{MULT_W{in_data[PSUM_W-1]}}, in_data})
                       * $signed({{PSUM_W{1'b0}}, cfg.mult});
            s1_valid_d = in_valid;
            s1_last_d  = in_valid & in_last;
        end else begin
            prod_d     = prod_q;
        end
    end

    // S2: one extra bit keeps the rounding add from overflowing
    always_comb begin
        if (cfg.shift != 5'd0) begin
            rnd = RND_ONE << (cfg.shift - 5'd1);
        end else begin
            rnd = '0;
        end
        biased  = {prod_q[PROD_W-1], prod_q} + rnd;
        shifted = biased >>> cfg.shift;
        if (cfg.relu && shifted[PROD_W]) begin
            relu_v = '0;
        end else begin
            relu_v = shifted;
        end
        zp_sum     = {relu_v[PROD_W], relu_v} + {{(PROD_W-6){cfg.zp[7]}}, cfg.zp};
        res_d      = res_q;
        s2_valid_d = s2_valid_q;
        s2_last_d  = s2_last_q;
        if (en) begin
            res_d      = sat_int8(zp_sum);
            s2_valid_d = s1_valid_q;
            s2_last_d  = s1_last_q;
        end else begin
            res_d      = res_q;
        end
    end

    // Stage registers
    always_ff @(posedge clk) begin
        if (rst) begin
            prod_q     <= '0;
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            res_q      <= '0;
            s2_valid_q <= 1'b0;
            s2_last_q  <= 1'b0;
        end else begin
            prod_q     <= prod_d;
            s1_valid_q <= s1_valid_d;
            s1_last_q  <= s1_last_d;
            res_q      <= res_d;
            s2_valid_q <= s2_valid_d;
            s2_last_q  <= s2_last_d;
        end
    end

    assign stage_valid = s1_valid_q | s2_valid_q;
    assign out_valid   = s2_valid_q;
    assign out_data    = res_q;
    assign out_last    = s2_last_q;
endmodule

// File: rtl/opsum_ppu.sv
// Opsum post-processing unit: requantises the psum stream to int8 and packs
// four results per word for the GLB, with a tile-last flush of partial words.
module opsum_ppu
    import ppu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_load,
    input  logic [MULT_W-1:0] cfg_mult,
    input  logic [4:0]        cfg_shift,
    input  logic [7:0]        cfg_zp,
    input  logic              cfg_relu,
    input  logic              in_valid,
    input  logic [PSUM_W-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              out_valid,
    output logic [OUT_W-1:0]  out_data,
    output logic [PACK-1:0]   out_bmask,
    output logic              out_last,
    input  logic              out_ready,
    output logic              busy,
    output logic              cfg_err
);
    ppu_cfg_t         cfg_d, cfg_q;
    logic             cfg_err_d, cfg_err_q;
    logic [OUT_W-1:0] data_d, data_q, data_base;
    logic [PACK-1:0]  bmask_d, bmask_q, bmask_base;
    logic [CNT_W-1:0] k_d, k_q;
    logic             out_valid_d, out_valid_q;
    logic             out_last_d, out_last_q;
    logic             stall;
    logic             stage_valid;
    logic             s2_valid;
    logic [7:0]       s2_data;
    logic             s2_last;

    assign stall    = out_valid_q & ~out_ready;
    assign in_ready = ~stall;
    assign busy     = stage_valid | (k_q != '0) | out_valid_q;

    ppu_requant u_requant (
        .clk         (clk),
        .rst         (rst),
        .en          (~stall),
        .cfg         (cfg_q),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_last     (in_last),
        .stage_valid (stage_valid),
        .out_valid   (s2_valid),
        .out_data    (s2_data),
        .out_last    (s2_last)
    );

    // Config is only accepted while idle; a load mid-tile latches the error flag
    always_comb begin
        cfg_d     = cfg_q;
        cfg_err_d = cfg_err_q;
        if (cfg_load) begin
            if (busy) begin
                cfg_err_d = 1'b1;
            end else begin
                cfg_d = '{mult: cfg_mult, shift: cfg_shift, zp: cfg_zp, relu: cfg_relu};
            end
        end else begin
            cfg_d = cfg_q;
        end
    end

    // Pack register: a word leaving this cycle frees the register for the incoming byte
    always_comb begin
        data_d      = data_q;
        bmask_d     = bmask_q;
        k_d         = k_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        data_base   = data_q;
        bmask_base  = bmask_q;
        if (!stall) begin
            if (out_valid_q) begin
                data_base  = '0;
                bmask_base = '0;
            end else begin
                data_base  = data_q;
                bmask_base = bmask_q;
            end
            data_d      = data_base;
            bmask_d     = bmask_base;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            if (s2_valid) begin
                data_d[{k_q, 3'b000} +: 8] = s2_data;
                bmask_d[k_q]               = 1'b1;
                if ((k_q == K_LAST) || s2_last) begin
                    out_valid_d = 1'b1;
                    out_last_d  = s2_last;
                    k_d         = '0;
                end else begin
                    k_d         = k_q + K_ONE;
                end
            end else begin
                k_d = k_q;
            end
        end else begin
            data_d = data_q;
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_q       <= CFG_RESET;
            cfg_err_q   <= 1'b0;
            data_q      <= '0;
            bmask_q     <= '0;
            k_q         <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            cfg_q       <= cfg_d;
            cfg_err_q   <= cfg_err_d;
            data_q      <= data_d;
            bmask_q     <= bmask_d;
            k_q         <= k_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = data_q;
    assign out_bmask = bmask_q;
    assign out_last  = out_last_q;
    assign cfg_err   = cfg_err_q;
endmodule

// File: tb/tb_opsum_ppu.sv
// Randomised self-checking bench for opsum_ppu; expected words come from an
// integer requant model and a byte-list packer kept inside the bench.
module tb_opsum_ppu;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_load = 1'b0;
    logic [15:0] cfg_mult = 16'd0;
    logic [4:0]  cfg_shift = 5'd0;
    logic [7:0]  cfg_zp = 8'd0;
    logic        cfg_relu = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = 32'd0;
    logic        in_last = 1'b0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic [3:0]  out_bmask;
    logic        out_last;
    logic        out_ready = 1'b1;
    logic        busy;
    logic        cfg_err;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  mask;
        logic        last;
        int          cyc;
    } word_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          last_acc_cyc = 0;
    bit          ready_random = 1'b0;
    word_t       obs_q[$];
    word_t       exp_q[$];
    word_t       saved_q[$];
    int unsigned m_mult = 1;
    int          m_shift = 0;
    int          m_zp = 0;
    bit          m_relu = 1'b0;
    logic [31:0] m_data = 32'd0;
    logic [3:0]  m_mask = 4'd0;
    int          m_k = 0;

    opsum_ppu dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_load  (cfg_load),
        .cfg_mult  (cfg_mult),
        .cfg_shift (cfg_shift),
        .cfg_zp    (cfg_zp),
        .cfg_relu  (cfg_relu),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_bmask (out_bmask),
        .out_last  (out_last),
        .out_ready (out_ready),
        .busy      (busy),
        .cfg_err   (cfg_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Word monitor: a handshake seen at the falling edge completes on the next rising edge
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            obs_q.push_back('{out_data, out_bmask, out_last, cyc});
        end
    end

    always @(posedge clk) begin
        if (ready_random) begin
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    function automatic logic [7:0] ref_q(input logic [31:0] psum);
        longint p;
        longint r;
        p = longint'($signed(psum)) * longint'(m_mult);
        if (m_shift == 0) r = p;
        else r = (p + (64'sd1 <<< (m_shift - 1))) >>> m_shift;
        if (m_relu && r < 0) r = 0;
        r = r + m_zp;
        if (r > 127) r = 127;
        else if (r < -128) r = -128;
        return r[7:0];
    endfunction

    task automatic model_push(input logic [7:0] b, input bit last);
        m_data[8*m_k +: 8] = b;
        m_mask[m_k] = 1'b1;
        m_k++;
        if (m_k == 4 || last) begin
            exp_q.push_back('{m_data, m_mask, last, 0});
            m_data = 32'd0;
            m_mask = 4'd0;
            m_k = 0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] psum, input bit last, input int gap);
        bit acc;
        acc = 1'b0;
        in_valid = 1'b1;
        in_data = psum;
        in_last = last;
        for (int t = 0; t < 200 && !acc; t++) begin
            @(negedge clk);
            if (in_ready) begin
                acc = 1'b1;
                last_acc_cyc = cyc;
            end
            step();
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready stayed %b, required 1", in_ready);
        end
        in_valid = 1'b0;
        in_last = 1'($urandom_range(0, 1));
        in_data = $urandom;
        model_push(ref_q(psum), last);
        repeat (gap) step();
    endtask

    task automatic cfg_set(input int unsigned mult, input int shift, input int zp, input bit relu);
        cfg_load = 1'b1;
        cfg_mult = mult[15:0];
        cfg_shift = shift[4:0];
        cfg_zp = zp[7:0];
        cfg_relu = relu;
        step();
        cfg_load = 1'b0;
        m_mult = mult;
        m_shift = shift;
        m_zp = zp;
        m_relu = relu;
    endtask

    task automatic drain_check(input string name);
        int t;
        t = 0;
        while ((busy || obs_q.size() < exp_q.size()) && t < 500) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL %s word_count: got %0d words, required %0d", name, obs_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                checks++;
                if ({obs_q[i].data, obs_q[i].mask, obs_q[i].last} !==
                    {exp_q[i].data, exp_q[i].mask, exp_q[i].last}) begin
                    errors++;
                    $display("FAIL %s word%0d: got data=%h mask=%h last=%b, required data=%h mask=%h last=%b",
                             name, i, obs_q[i].data, obs_q[i].mask, obs_q[i].last,
                             exp_q[i].data, exp_q[i].mask, exp_q[i].last);
                end
            end
        end
        saved_q = obs_q;
        obs_q.delete();
        exp_q.delete();
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({in_ready, out_valid, out_data, out_bmask, out_last, busy, cfg_err} !==
            {1'b1, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: got rdy=%b ov=%b d=%h m=%h l=%b busy=%b err=%b, required rdy=1 rest 0",
                     in_ready, out_valid, out_data, out_bmask, out_last, busy, cfg_err);
        end
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_identity();
        for (int i = 0; i < 4; i++) send(32'(i + 1), i == 3, 0);
        drain_check("identity");
        checks++;
        if (saved_q.size() < 1 || saved_q[0].data !== 32'h04030201 || saved_q[0].mask !== 4'hF) begin
            errors++;
            $display("FAIL identity_word: got %h/%h, required 04030201/f",
                     saved_q.size() > 0 ? saved_q[0].data : 32'h0, saved_q.size() > 0 ? saved_q[0].mask : 4'h0);
        end
        checks++;
        if (saved_q.size() < 1 || saved_q[0].cyc - last_acc_cyc != 3) begin
            errors++;
            $display("FAIL identity_latency: got %0d cycles, required 3",
                     saved_q.size() > 0 ? saved_q[0].cyc - last_acc_cyc : -1);
        end
    endtask

    task automatic test_vectors();
        cfg_set(3, 2, 0, 1'b0);
        send(32'd5, 1'b0, 0);
        send(-32'sd5, 1'b0, 1);
        send(32'd1000, 1'b0, 0);
        send(-32'sd1000, 1'b1, 0);
        drain_check("round_clamp");
        checks++;
        if (saved_q.size() < 1 || saved_q[0].data !== 32'h807FFC04) begin
            errors++;
            $display("FAIL round_clamp_word: got %h, required 807ffc04",
                     saved_q.size() > 0 ? saved_q[0].data : 32'h0);
        end
        cfg_set(1, 0, 10, 1'b1);
        send(-32'sd7, 1'b0, 0);
        send(32'd200, 1'b1, 0);
        drain_check("relu_zp");
        checks++;
        if (saved_q.size() < 1 || saved_q[0].data !== 32'h00007F0A || saved_q[0].mask !== 4'h3) begin
            errors++;
            $display("FAIL relu_zp_word: got %h/%h, required 00007f0a/3",
                     saved_q.size() > 0 ? saved_q[0].data : 32'h0, saved_q.size() > 0 ? saved_q[0].mask : 4'h0);
        end
    endtask

    task automatic test_partial();
        cfg_set(5, 3, -4, 1'b0);
        for (int i = 0; i < 6; i++) send($urandom_range(0, 400) - 200, i == 5, $urandom_range(0, 1));
        drain_check("partial");
        checks++;
        if (saved_q.size() != 2 || saved_q[1].mask !== 4'h3 || saved_q[1].data[31:16] !== 16'h0
            || saved_q[1].last !== 1'b1 || saved_q[0].last !== 1'b0) begin
            errors++;
            $display("FAIL partial_tail: got %0d words, tail mask=%h, required 2 words, tail mask=3",
                     saved_q.size(), saved_q.size() > 1 ? saved_q[1].mask : 4'h0);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] held;
        bit          prev_rdy;
        int          t;
        cfg_set(1, 0, 0, 1'b0);
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 16; i++) send(32'(i + 1), i == 15, 0);
            end
            begin
                prev_rdy = 1'b1;
                t = 0;
                @(negedge clk);
                while (!out_valid && t < 100) begin
                    prev_rdy = in_ready;
                    @(negedge clk);
                    t++;
                end
                checks++;
                if (!(out_valid && prev_rdy && !in_ready)) begin
                    errors++;
                    $display("FAIL stall_entry: got ov=%b rdy_before=%b rdy=%b, required 1 1 0",
                             out_valid, prev_rdy, in_ready);
                end
                held = out_data;
                repeat (4) begin
                    @(negedge clk);
                    checks++;
                    if (out_data !== held || !out_valid || in_ready) begin
                        errors++;
                        $display("FAIL stall_hold: got d=%h ov=%b rdy=%b, required d=%h ov=1 rdy=0",
                                 out_data, out_valid, in_ready, held);
                    end
                end
                step();
                out_ready = 1'b1;
            end
        join
        drain_check("backpressure");
        for (int i = 1; i < 4; i++) begin
            checks++;
            if (saved_q.size() != 4 || saved_q[i].cyc - saved_q[i-1].cyc != 4) begin
                errors++;
                $display("FAIL stream_rate: word%0d gap got %0d, required 4", i,
                         saved_q.size() == 4 ? saved_q[i].cyc - saved_q[i-1].cyc : -1);
            end
        end
    endtask

    task automatic test_cfg_err();
        cfg_set(2, 1, 0, 1'b0);
        send(32'd10, 1'b0, 0);
        send(32'd20, 1'b0, 0);
        cfg_load = 1'b1;
        cfg_mult = 16'd7;
        cfg_shift = 5'd0;
        cfg_zp = 8'd50;
        cfg_relu = 1'b1;
        step();
        cfg_load = 1'b0;
        @(negedge clk);
        checks++;
        if (cfg_err !== 1'b1) begin
            errors++;
            $display("FAIL cfg_err_set: got %b, required 1", cfg_err);
        end
        step();
        send(-32'sd30, 1'b0, 0);
        send(32'd40, 1'b1, 0);
        drain_check("cfg_ignored");
        checks++;
        if (cfg_err !== 1'b1) begin
            errors++;
            $display("FAIL cfg_err_sticky: got %b, required 1", cfg_err);
        end
    endtask

    task automatic test_rst_mid();
        for (int i = 0; i < 3; i++) send($urandom, 1'b0, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || cfg_err !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid: got busy=%b ov=%b err=%b, required 0 0 0", busy, out_valid, cfg_err);
        end
        m_mult = 1; m_shift = 0; m_zp = 0; m_relu = 1'b0;
        m_data = 32'd0; m_mask = 4'd0; m_k = 0;
        obs_q.delete();
        exp_q.delete();
        step();
        for (int i = 0; i < 4; i++) send($urandom_range(0, 250) - 125, i == 3, 0);
        drain_check("after_rst");
    endtask

    task automatic test_back_to_back();
        int len;
        ready_random = 1'b1;
        for (int it = 0; it < 8; it++) begin
            cfg_set((it % 3 == 0) ? $urandom : $urandom_range(0, 300), $urandom_range(0, 12),
                    $urandom_range(0, 255) - 128, 1'($urandom_range(0, 1)));
            for (int tile = 0; tile < 2; tile++) begin
                len = $urandom_range(1, 9);
                for (int i = 0; i < len; i++) begin
                    send(($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 4000)) - 32'd2000,
                         i == len - 1, $urandom_range(0, 2) == 0 ? 1 : 0);
                end
            end
            drain_check("random");
        end
        ready_random = 1'b0;
        step();
        out_ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_identity();
        test_vectors();
        test_partial();
        test_backpressure();
        test_cfg_err();
        test_rst_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
